// File: rtl/lfsr_bus_sched.sv
// rtl/lfsr_bus_sched.sv - round-robin word-read scheduler for the 16-channel LFSR bus array
// One request is granted at a time, strobed onto (a, rd), and the addressed word is returned with its requester ID.
module lfsr_bus_sched #(
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1,
    parameter int IDW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        a,
    output logic              rd,
    input  logic [511:0]      d_bus,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [IDW-1:0]    rid,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n, id_q, id_n, rid_n, win, hi_win, lo_win;
    logic [3:0]     addr_q, addr_n;
    logic [2:0]     cnt, cnt_n;
    logic [NREQ-1:0] gnt_n;
    logic [31:0]    rdata_n;
    logic           rd_n, rvalid_n, busy_n, hi_found;

    // Two-pass search: lowest requester above ptr wins, else lowest at or below ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = IDW'(i);
                end else begin
                    lo_win = IDW'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        id_n     = id_q;
        addr_n   = addr_q;
        cnt_n    = cnt;
        gnt_n    = '0;
        rd_n     = 1'b0;
        rvalid_n = 1'b0;
        rdata_n  = rdata;
        rid_n    = rid;
        case (state)
            IDLE: begin
                if (|req) begin
                    id_n    = win;
                    addr_n  = req_addr[{win, 2'b00} +: 4];
                    ptr_n   = win;
                    gnt_n   = NREQ'(1) << win;
                    rd_n    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = 3'(RD_LAT - 1);
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    rdata_n  = d_bus[{addr_q, 5'b00000} +: 32];
                    rid_n    = id_q;
                    rvalid_n = 1'b1;
                    state_n  = RESP;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= IDW'(NREQ - 1);
            id_q   <= '0;
            addr_q <= '0;
            cnt    <= '0;
            gnt    <= '0;
            rd     <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
            busy   <= 1'b0;
        end else begin
            ptr    <= ptr_n;
            id_q   <= id_n;
            addr_q <= addr_n;
            cnt    <= cnt_n;
            gnt    <= gnt_n;
            rd     <= rd_n;
            rvalid <= rvalid_n;
            rdata  <= rdata_n;
            rid    <= rid_n;
            busy   <= busy_n;
        end
    end

    assign a = addr_q;

endmodule
